// File: rtl/doorway_direction_decoder_if.sv
// Beam inputs and event/debug outputs of one doorway decoder.
// With DIR_EVENT_COUNT_EN defined, the interface also carries the saturating event totals.
interface doorway_direction_decoder_if;
    logic       beam_a;
    logic       beam_b;
    logic       entry_out;
    logic       exit_out;
    logic       abort_pulse;
    logic       overflow_pulse;
    logic       busy;
    logic [3:0] dir_state;
`ifdef DIR_EVENT_COUNT_EN
    logic [15:0] entry_total;
    logic [15:0] exit_total;
    logic [15:0] abort_total;

    modport slave (
        input  beam_a, beam_b,
        output entry_out, exit_out, abort_pulse, overflow_pulse, busy, dir_state,
        output entry_total, exit_total, abort_total
    );
    modport master (
        output beam_a, beam_b,
        input  entry_out, exit_out, abort_pulse, overflow_pulse, busy, dir_state,
        input  entry_total, exit_total, abort_total
    );
`else
    modport slave (
        input  beam_a, beam_b,
        output entry_out, exit_out, abort_pulse, overflow_pulse, busy, dir_state
    );
    modport master (
        output beam_a, beam_b,
        input  entry_out, exit_out, abort_pulse, overflow_pulse, busy, dir_state
    );
`endif
endinterface

// File: rtl/doorway_direction_decoder.sv
// Two-beam doorway decoder: synchronize and debounce beams, track crossing order, queue and stretch entry/exit events.
// Optional macro DIR_EVENT_COUNT_EN adds saturating entry/exit/abort totals.
module doorway_direction_decoder #(
    parameter int unsigned DEBOUNCE_LIMIT = 2_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
    parameter int unsigned PULSE_LEN      = 3_000_000,
    parameter int unsigned GAP_LEN        = 3_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    doorway_direction_decoder_if.slave    bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_A1         = 4'd1,
        S_A2         = 4'd2,
        S_A3         = 4'd3,
        S_B1         = 4'd4,
        S_B2         = 4'd5,
        S_B3         = 4'd6,
        S_WAIT_CLEAR = 4'd7
    } dir_t;

    typedef enum logic [1:0] {
        E_IDLE  = 2'd0,
        E_PULSE = 2'd1,
        E_GAP   = 2'd2
    } emit_t;

    // Bit 0 is beam A, bit 1 is beam B throughout the input path.
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  stable;
    logic [31:0] deb_cnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= {bus.beam_b, bus.beam_a};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] + 32'd1 >= DEBOUNCE_LIMIT) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    dir_t        dir_q;
    dir_t        dir_d;
    logic [31:0] dir_timer;
    logic [1:0]  ab;
    logic        crossing;
    logic        timed_out;
    logic        ev_entry;
    logic        ev_exit;
    logic        ev_abort;

    assign ab        = {stable[0], stable[1]};
    assign crossing  = (dir_q != S_IDLE) && (dir_q != S_WAIT_CLEAR);
    assign timed_out = crossing && (dir_timer + 32'd1 >= TIMEOUT_CYCLES);

    always_comb begin
        dir_d    = dir_q;
        ev_entry = 1'b0;
        ev_exit  = 1'b0;
        ev_abort = 1'b0;
        if (timed_out) begin
            dir_d    = S_WAIT_CLEAR;
            ev_abort = 1'b1;
        end else begin
            case (dir_q)
                S_IDLE: case (ab)
                    2'b10: dir_d = S_A1;
                    2'b01: dir_d = S_B1;
                    2'b11: begin dir_d = S_WAIT_CLEAR; ev_abort = 1'b1; end
                    default: ;
                endcase
                S_A1: case (ab)
                    2'b11: dir_d = S_A2;
                    2'b01: dir_d = S_A3;
                    2'b00: dir_d = S_IDLE;
                    default: ;
                endcase
                S_A2: case (ab)
                    2'b10: dir_d = S_A1;
                    2'b01: dir_d = S_A3;
                    2'b00: begin dir_d = S_IDLE; ev_abort = 1'b1; end
                    default: ;
                endcase
                S_A3: case (ab)
                    2'b00: begin dir_d = S_IDLE; ev_entry = 1'b1; end
                    2'b11: dir_d = S_A2;
                    2'b10: dir_d = S_A1;
                    default: ;
                endcase
                S_B1: case (ab)
                    2'b11: dir_d = S_B2;
                    2'b10: dir_d = S_B3;
                    2'b00: dir_d = S_IDLE;
                    default: ;
                endcase
                S_B2: case (ab)
                    2'b01: dir_d = S_B1;
                    2'b10: dir_d = S_B3;
                    2'b00: begin dir_d = S_IDLE; ev_abort = 1'b1; end
                    default: ;
                endcase
                S_B3: case (ab)
                    2'b00: begin dir_d = S_IDLE; ev_exit = 1'b1; end
                    2'b11: dir_d = S_B2;
                    2'b01: dir_d = S_B1;
                    default: ;
                endcase
                S_WAIT_CLEAR: if (ab == 2'b00) dir_d = S_IDLE;
                default: dir_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q     <= S_IDLE;
            dir_timer <= '0;
        end else begin
            dir_q     <= dir_d;
            dir_timer <= (dir_d != dir_q) ? 32'd0 : dir_timer + 32'd1;
        end
    end

    logic [1:0]  pend_entry;
    logic [1:0]  pend_exit;
    logic        push_entry;
    logic        push_exit;
    logic        pop_entry;
    logic        pop_exit;
    logic        drop;

    assign push_entry = ev_entry && (pend_entry != 2'd3);
    assign push_exit  = ev_exit  && (pend_exit  != 2'd3);
    assign drop       = (ev_entry && (pend_entry == 2'd3)) || (ev_exit && (pend_exit == 2'd3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_entry <= '0;
            pend_exit  <= '0;
        end else begin
            case ({push_entry, pop_entry})
                2'b10:   pend_entry <= pend_entry + 2'd1;
                2'b01:   pend_entry <= pend_entry - 2'd1;
                default: ;
            endcase
            case ({push_exit, pop_exit})
                2'b10:   pend_exit <= pend_exit + 2'd1;
                2'b01:   pend_exit <= pend_exit - 2'd1;
                default: ;
            endcase
        end
    end

    emit_t       emit_q;
    emit_t       emit_d;
    logic [31:0] emit_timer;
    logic        last_entry;
    logic        gap_done;
    logic        slot_free;
    logic        entry_r;
    logic        exit_r;

    // The last gap cycle may launch the next pulse directly, so back-to-back pulses sit exactly GAP_LEN low cycles apart.
    assign gap_done  = (emit_q == E_GAP) && (emit_timer + 32'd1 >= GAP_LEN);
    assign slot_free = (emit_q == E_IDLE) || gap_done;

    always_comb begin
        emit_d    = emit_q;
        pop_entry = 1'b0;
        pop_exit  = 1'b0;
        case (emit_q)
            E_PULSE: if (emit_timer + 32'd1 >= PULSE_LEN) emit_d = E_GAP;
            E_GAP:   if (gap_done) emit_d = E_IDLE;
            default: ;
        endcase
        if (slot_free) begin
            if ((pend_entry != 2'd0) && ((pend_exit == 2'd0) || !last_entry)) begin
                pop_entry = 1'b1;
            end else if (pend_exit != 2'd0) begin
                pop_exit = 1'b1;
            end
            if (pop_entry || pop_exit) emit_d = E_PULSE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_q         <= E_IDLE;
            emit_timer     <= '0;
            last_entry     <= 1'b0;
            entry_r        <= 1'b0;
            exit_r         <= 1'b0;
            bus.abort_pulse    <= 1'b0;
            bus.overflow_pulse <= 1'b0;
        end else begin
            emit_q     <= emit_d;
            emit_timer <= (emit_d != emit_q) ? 32'd0 : emit_timer + 32'd1;
            if (pop_entry)     last_entry <= 1'b1;
            else if (pop_exit) last_entry <= 1'b0;
            entry_r            <= pop_entry || (entry_r && (emit_d == E_PULSE));
            exit_r             <= pop_exit  || (exit_r  && (emit_d == E_PULSE));
            bus.abort_pulse    <= ev_abort;
            bus.overflow_pulse <= drop;
        end
    end

    assign bus.entry_out = entry_r;
    assign bus.exit_out  = exit_r;
    assign bus.busy      = (emit_q != E_IDLE) || (pend_entry != 2'd0) || (pend_exit != 2'd0);
    assign bus.dir_state = dir_q;

`ifdef DIR_EVENT_COUNT_EN
    logic [15:0] entry_total;
    logic [15:0] exit_total;
    logic [15:0] abort_total;

    // Totals count FSM decisions, so events later dropped on overflow are still included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_total <= '0;
            exit_total  <= '0;
            abort_total <= '0;
        end else begin
            if (ev_entry && (entry_total != 16'hFFFF)) entry_total <= entry_total + 16'd1;
            if (ev_exit  && (exit_total  != 16'hFFFF)) exit_total  <= exit_total  + 16'd1;
            if (ev_abort && (abort_total != 16'hFFFF)) abort_total <= abort_total + 16'd1;
        end
    end

    assign bus.entry_total = entry_total;
    assign bus.exit_total  = exit_total;
    assign bus.abort_total = abort_total;
`endif

endmodule

// File: tb/tb_doorway_direction_decoder.sv
// Scoreboard bench for doorway_direction_decoder: instance 0 uses the short test timing,
// instance 1 uses a long pulse so a burst of entries can fill the event queue.
module tb_doorway_direction_decoder;

    localparam int P_DEB         = 4;
    localparam int P_TO          = 100;
    localparam int P_PULSE       = 8;
    localparam int P_GAP         = 4;
    localparam int P_BURST_PULSE = 400;
    localparam int ST_IDLE       = 0;
    localparam int ST_A2         = 2;
    localparam int ST_WAIT       = 7;
    localparam int K_ENTRY       = 1;
    localparam int K_EXIT        = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    int sb0[$];
    int sb1[$];
    int abort_cnt [2];
    int ovf_cnt   [2];
    int cur_kind  [2];
    int run_len   [2];
    int low_len   [2];
    int pulses    [2];
    bit glitch_watch = 1'b0;
    bit glitch_seen  = 1'b0;
    bit rst_watch    = 1'b0;
    bit rst_seen_out = 1'b0;

    doorway_direction_decoder_if bus0 ();
    doorway_direction_decoder_if bus1 ();

    doorway_direction_decoder #(
        .DEBOUNCE_LIMIT(P_DEB), .TIMEOUT_CYCLES(P_TO), .PULSE_LEN(P_PULSE), .GAP_LEN(P_GAP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    doorway_direction_decoder #(
        .DEBOUNCE_LIMIT(P_DEB), .TIMEOUT_CYCLES(P_TO), .PULSE_LEN(P_BURST_PULSE), .GAP_LEN(P_GAP)
    ) dut_burst (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Pulses are popped against the scoreboard on their rising edge; length and gap are checked on the edges.
    task automatic monitorTick(input int inst, input int kind, input int plen, input bit exact_gap);
        int exp_kind;
        if (kind != 0 && cur_kind[inst] == 0) begin
            if (pulses[inst] > 0) begin
                if (exact_gap) checkOutput("gap_len", low_len[inst], P_GAP);
                else           checkOutput("gap_min", int'(low_len[inst] >= P_GAP), 1);
            end
            exp_kind = 0;
            if (inst == 0) begin
                if (sb0.size() != 0) exp_kind = sb0.pop_front();
            end else begin
                if (sb1.size() != 0) exp_kind = sb1.pop_front();
            end
            checkOutput("pulse_kind", kind, exp_kind);
            pulses[inst]++;
            run_len[inst] = 1;
        end else if (kind != 0) begin
            if (kind != cur_kind[inst]) checkOutput("pulse_switch", kind, cur_kind[inst]);
            run_len[inst]++;
        end else if (cur_kind[inst] != 0) begin
            checkOutput("pulse_len", run_len[inst], plen);
            low_len[inst] = 1;
        end else begin
            low_len[inst]++;
        end
        cur_kind[inst] = kind;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                cur_kind[i] = 0;
                run_len[i]  = 0;
                low_len[i]  = 0;
                pulses[i]   = 0;
            end
        end else begin
            monitorTick(0, int'({bus0.exit_out, bus0.entry_out}), P_PULSE, 1'b0);
            monitorTick(1, int'({bus1.exit_out, bus1.entry_out}), P_BURST_PULSE, 1'b1);
            if (bus0.abort_pulse)    abort_cnt[0]++;
            if (bus1.abort_pulse)    abort_cnt[1]++;
            if (bus0.overflow_pulse) ovf_cnt[0]++;
            if (bus1.overflow_pulse) ovf_cnt[1]++;
            if (glitch_watch && bus0.dir_state != 4'd0) glitch_seen = 1'b1;
        end
        if (rst_watch && (bus0.entry_out || bus0.exit_out || bus0.busy)) rst_seen_out = 1'b1;
    end

    task automatic setBeams(input int inst, input logic a, input logic b, input int cycles);
        if (inst == 0) begin
            bus0.beam_a = a;
            bus0.beam_b = b;
        end else begin
            bus1.beam_a = a;
            bus1.beam_b = b;
        end
        if (cycles > 0) begin
            repeat (cycles) @(posedge clk);
            #1;
        end
    endtask

    // kind: 1 entry, 2 exit, 3 back-out on A, 4 three-cycle glitch on A.
    task automatic applyStimulus(input int inst, input int kind, input int hold, input bit expect_emit);
        if (expect_emit && (kind == K_ENTRY || kind == K_EXIT)) begin
            if (inst == 0) sb0.push_back(kind);
            else           sb1.push_back(kind);
        end
        case (kind)
            1: begin
                setBeams(inst, 1'b1, 1'b0, hold);
                setBeams(inst, 1'b1, 1'b1, hold);
                setBeams(inst, 1'b0, 1'b1, hold);
                setBeams(inst, 1'b0, 1'b0, hold);
            end
            2: begin
                setBeams(inst, 1'b0, 1'b1, hold);
                setBeams(inst, 1'b1, 1'b1, hold);
                setBeams(inst, 1'b1, 1'b0, hold);
                setBeams(inst, 1'b0, 1'b0, hold);
            end
            3: begin
                setBeams(inst, 1'b1, 1'b0, hold);
                setBeams(inst, 1'b0, 1'b0, hold);
            end
            default: begin
                setBeams(inst, 1'b1, 1'b0, 3);
                setBeams(inst, 1'b0, 1'b0, hold);
            end
        endcase
    endtask

    task automatic waitDrain(input string tag, input int inst, input int budget);
        int n = 0;
        while (n < budget && (inst == 0 ? (sb0.size() != 0 || bus0.busy)
                                        : (sb1.size() != 0 || bus1.busy))) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, int'(n < budget), 1);
        checkOutput("sb_empty", inst == 0 ? sb0.size() : sb1.size(), 0);
    endtask

    initial begin
        int a0, p0, o1, n;
        for (int i = 0; i < 2; i++) begin
            abort_cnt[i] = 0;
            ovf_cnt[i]   = 0;
        end
        bus0.beam_a = 1'b0; bus0.beam_b = 1'b0;
        bus1.beam_a = 1'b0; bus1.beam_b = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_entry_out", int'(bus0.entry_out), 0);
        checkOutput("rst_exit_out",  int'(bus0.exit_out), 0);
        checkOutput("rst_abort",     int'(bus0.abort_pulse), 0);
        checkOutput("rst_overflow",  int'(bus0.overflow_pulse), 0);
        checkOutput("rst_busy",      int'(bus0.busy), 0);
        checkOutput("rst_dir_state", int'(bus0.dir_state), ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;

        $display("[TB] entry crossing");
        a0 = abort_cnt[0]; p0 = pulses[0];
        applyStimulus(0, K_ENTRY, 20, 1'b1);
        waitDrain("entry_drain", 0, 200);
        checkOutput("entry_pulses", pulses[0] - p0, 1);
        checkOutput("entry_no_abort", abort_cnt[0] - a0, 0);

        $display("[TB] exit crossing");
        a0 = abort_cnt[0]; p0 = pulses[0];
        applyStimulus(0, K_EXIT, 20, 1'b1);
        waitDrain("exit_drain", 0, 200);
        checkOutput("exit_pulses", pulses[0] - p0, 1);
        checkOutput("exit_no_abort", abort_cnt[0] - a0, 0);

        $display("[TB] back-out");
        a0 = abort_cnt[0]; p0 = pulses[0];
        applyStimulus(0, 3, 20, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("backout_pulses", pulses[0] - p0, 0);
        checkOutput("backout_no_abort", abort_cnt[0] - a0, 0);
        checkOutput("backout_idle", int'(bus0.dir_state), ST_IDLE);

        $display("[TB] glitch");
        glitch_watch = 1'b1;
        applyStimulus(0, 4, 20, 1'b0);
        glitch_watch = 1'b0;
        checkOutput("glitch_fsm_idle", int'(glitch_seen), 0);

        $display("[TB] stall");
        a0 = abort_cnt[0]; p0 = pulses[0];
        setBeams(0, 1'b1, 1'b0, 20);
        setBeams(0, 1'b1, 1'b1, 0);
        n = 0;
        while (n < 60 && int'(bus0.dir_state) != ST_A2) begin @(negedge clk); n++; end
        checkOutput("stall_reach_a2", int'(bus0.dir_state), ST_A2);
        n = 0;
        while (n < 200 && !bus0.abort_pulse) begin @(negedge clk); n++; end
        checkOutput("stall_abort_delay", n, P_TO);
        repeat (30) @(negedge clk);
        checkOutput("stall_wait_clear", int'(bus0.dir_state), ST_WAIT);
        setBeams(0, 1'b0, 1'b0, 20);
        checkOutput("stall_back_idle", int'(bus0.dir_state), ST_IDLE);
        checkOutput("stall_abort_count", abort_cnt[0] - a0, 1);
        checkOutput("stall_pulses", pulses[0] - p0, 0);

        $display("[TB] burst of five entries");
        o1 = ovf_cnt[1];
        for (int i = 0; i < 5; i++) applyStimulus(1, K_ENTRY, 8, i < 4);
        waitDrain("burst_drain", 1, 3000);
        checkOutput("burst_overflow", ovf_cnt[1] - o1, 1);
        checkOutput("burst_pulses", pulses[1], 4);
        checkOutput("burst_no_abort", abort_cnt[1], 0);

        $display("[TB] reset mid-pulse");
        sb0.push_back(K_ENTRY);
        setBeams(0, 1'b1, 1'b0, 20);
        setBeams(0, 1'b1, 1'b1, 20);
        setBeams(0, 1'b0, 1'b1, 20);
        setBeams(0, 1'b0, 1'b0, 0);
        n = 0;
        while (n < 40 && !bus0.entry_out) begin @(negedge clk); n++; end
        checkOutput("midrst_pulse_started", int'(bus0.entry_out), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_entry_async", int'(bus0.entry_out), 0);
        checkOutput("midrst_exit_async",  int'(bus0.exit_out), 0);
        checkOutput("midrst_busy_async",  int'(bus0.busy), 0);
        sb0.delete();
        rst_watch = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        rst_watch = 1'b0;
        checkOutput("midrst_outputs_stay_low", int'(rst_seen_out), 0);
        checkOutput("midrst_idle", int'(bus0.dir_state), ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
